// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light codes, phase states and phase durations for the T-junction controller
package tlc_pkg;

  // One-hot head codes, bit order {R,Y,G}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Default phase durations in 1 Hz ticks
  localparam int T_S1_DEF  = 7;
  localparam int T_S2_DEF  = 2;
  localparam int T_S3_DEF  = 5;
  localparam int T_S4_DEF  = 2;
  localparam int T_S5_DEF  = 3;
  localparam int T_S6_DEF  = 2;
  localparam int CNT_W_DEF = 4;

  // Six legal phases; codes 6 and 7 are illegal and recover to S1
  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } state_t;

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - per-phase tick counter with terminal-count flag
module tlc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] last,
  input  logic             clear,
  output logic             done
);

  logic [CNT_W-1:0] count;
  logic             armed;

  // The first edge after reset only arms the timer: it is the edge that
  // opens cycle 1 of S1, so counting starts on the edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (done || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Terminal count: the next edge leaves the current phase
  assign done = armed && (count == last);

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time six-phase Moore controller for a T-junction
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int T_S1  = T_S1_DEF,
  parameter int T_S2  = T_S2_DEF,
  parameter int T_S3  = T_S3_DEF,
  parameter int T_S4  = T_S4_DEF,
  parameter int T_S5  = T_S5_DEF,
  parameter int T_S6  = T_S6_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT
);

  state_t           state;
  logic [CNT_W-1:0] phase_last;
  logic             illegal;
  logic             done;

  // Terminal count for the current phase; illegal codes get zero so the
  // timer never holds the FSM in a bad encoding
  always_comb begin
    phase_last = '0;
    illegal    = 1'b0;
    case (state)
      S1:      phase_last = CNT_W'(T_S1 - 1);
      S2:      phase_last = CNT_W'(T_S2 - 1);
      S3:      phase_last = CNT_W'(T_S3 - 1);
      S4:      phase_last = CNT_W'(T_S4 - 1);
      S5:      phase_last = CNT_W'(T_S5 - 1);
      S6:      phase_last = CNT_W'(T_S6 - 1);
      default: illegal    = 1'b1;
    endcase
  end

  tlc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .last  (phase_last),
    .clear (illegal),
    .done  (done)
  );

  // Phase sequencing: fixed ring S1..S6, any illegal code returns to S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S1;
    end else begin
      case (state)
        S1:      if (done) state <= S2;
        S2:      if (done) state <= S3;
        S3:      if (done) state <= S4;
        S4:      if (done) state <= S5;
        S5:      if (done) state <= S6;
        S6:      if (done) state <= S1;
        default: state <= S1;
      endcase
    end
  end

  // Head decode straight from the state; illegal codes show all red
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state)
      S1: begin light_M1 = GREEN;  light_M2 = GREEN;  end
      S2: begin light_M1 = GREEN;  light_M2 = YELLOW; end
      S3: begin light_M1 = GREEN;  light_MT = GREEN;  end
      S4: begin light_M1 = YELLOW; light_MT = YELLOW; end
      S5: light_S = GREEN;
      S6: light_S = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed self-checking bench for traffic_light_controller
module tb_traffic_light_controller;

  logic       clk;
  logic       rst;
  logic [2:0] light_M1;
  logic [2:0] light_S;
  logic [2:0] light_M2;
  logic [2:0] light_MT;

  int n_checks;
  int n_fail;
  int k;

  // Expected heads per phase, packed {M1,M2,MT,S}
  localparam logic [11:0] H_S1 = {3'b001, 3'b001, 3'b100, 3'b100};
  localparam logic [11:0] H_S2 = {3'b001, 3'b010, 3'b100, 3'b100};
  localparam logic [11:0] H_S3 = {3'b001, 3'b100, 3'b001, 3'b100};
  localparam logic [11:0] H_S4 = {3'b010, 3'b100, 3'b010, 3'b100};
  localparam logic [11:0] H_S5 = {3'b100, 3'b100, 3'b100, 3'b001};
  localparam logic [11:0] H_S6 = {3'b100, 3'b100, 3'b100, 3'b010};

  traffic_light_controller dut (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (light_M1),
    .light_S  (light_S),
    .light_M2 (light_M2),
    .light_MT (light_MT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] heads();
    return {light_M1, light_M2, light_MT, light_S};
  endfunction

  // Expected heads k edges after reset release; edge 1 opens cycle 1 of S1
  function automatic logic [11:0] exp_heads(input int edges);
    int p;
    if (edges <= 0) return H_S1;
    p = (edges - 1) % 21;
    if (p < 7)  return H_S1;
    if (p < 9)  return H_S2;
    if (p < 14) return H_S3;
    if (p < 16) return H_S4;
    if (p < 19) return H_S5;
    return H_S6;
  endfunction

  function automatic logic legal(input logic [2:0] h);
    return (h == 3'b100) || (h == 3'b010) || (h == 3'b001);
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    k++;
    check_eq($sformatf("%s_e%0d", tag, k), heads(), exp_heads(k));
  endtask

  // Safety and encoding invariants sampled on every falling edge
  always @(negedge clk) begin
    check_eq("legal_codes",
             {11'd0, legal(light_M1) & legal(light_M2) & legal(light_MT) & legal(light_S)}, 12'd1);
    check_eq("side_excl",
             {11'd0, (light_S == 3'b100) ||
                     (light_M1 == 3'b100 && light_M2 == 3'b100 && light_MT == 3'b100)}, 12'd1);
    check_eq("turn_excl",
             {11'd0, (light_MT == 3'b100) || (light_M2 == 3'b100)}, 12'd1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    rst      = 1'b1;

    #12;
    check_eq("in_reset", heads(), H_S1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("after_release", heads(), H_S1);

    // First full cycle with explicit boundary spot checks
    for (int i = 0; i < 7; i++) step("s1_hold");
    step("s2_entry");
    check_eq("e8_m2_yellow", {9'd0, light_M2}, 12'h002);
    step("s2_end");
    step("s3_entry");
    check_eq("e10_mt_green", {9'd0, light_MT}, 12'h001);
    check_eq("e10_m2_red", {9'd0, light_M2}, 12'h004);
    for (int i = 0; i < 12; i++) step("cycle1");
    check_eq("e22_back_s1", heads(), H_S1);

    // Long run: sequence must stay periodic
    for (int i = 0; i < 200; i++) step("periodic");

    // Advance to the middle cycle of S5, then reset asynchronously
    while (((k - 1) % 21) != 17) step("to_s5");
    check_eq("mid_s5", heads(), H_S5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset", heads(), H_S1);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) step("rerun_s1");
    step("rerun_s2");
    for (int i = 0; i < 14; i++) step("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
